cv32e41s_obi_arbiter: RTL

//  Shares one OBI master port between two requesters (m0, m1), e.g. the data LSU and the debug/DMA path.

---
 rtl/cv32e41s_pkg.sv | 28 ++
 rtl/cv32e41s_obi_arb_id_fifo.sv | 63 ++++++
 rtl/cv32e41s_obi_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cv32e41s_pkg.sv
// Shared types and helpers for the two-requester OBI arbiter.
package cv32e41s_pkg;

  typedef enum logic {
    OBI_ARB_IDLE   = 1'b0,
    OBI_ARB_LOCKED = 1'b1
  } obi_arb_state_e;

  typedef logic obi_arb_id_t;

  localparam obi_arb_id_t OBI_ID_M0 = 1'b0;
  localparam obi_arb_id_t OBI_ID_M1 = 1'b1;

  // With both requesting, round-robin hands the bus to whoever did not win last.
  function automatic obi_arb_id_t obi_arb_pick(
    input logic        m0_req,
    input logic        m1_req,
    input obi_arb_id_t rr_last,
    input logic        fixed_prio
  );
    if (m0_req && m1_req) begin
      if (fixed_prio) return OBI_ID_M0;
      return (rr_last == OBI_ID_M0) ? OBI_ID_M1 : OBI_ID_M0;
    end
    return m1_req ? OBI_ID_M1 : OBI_ID_M0;
  endfunction

endpackage

// File: rtl/cv32e41s_obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted, not yet answered bus transactions.
module cv32e41s_obi_arb_id_fifo
  import cv32e41s_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  obi_arb_id_t       push_id_i,
  input  logic              pop_i,
  output obi_arb_id_t       head_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  obi_arb_id_t             mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    push_en;
  logic                    pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot the push would otherwise overflow into.
  assign push_en = push_i && (!full_o || pop_i);
  assign pop_en  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is left unreset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/cv32e41s_obi_arbiter.sv
// Two-requester OBI address-phase arbiter with outstanding cap and in-order response routing.
module cv32e41s_obi_arbiter
  import cv32e41s_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned FIXED_PRIO      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  obi_arb_state_e   state_q, state_d;
  obi_arb_id_t      sel_q, sel_d;
  obi_arb_id_t      rr_last_q, rr_last_d;
  obi_arb_id_t      bus_sel;
  obi_arb_id_t      head_id;
  logic             bus_req;
  logic             push;
  logic             rsp_pop;
  logic             lock_err;
  logic             sel_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] cnt_q;

  assign sel_req = (sel_q == OBI_ID_M1) ? m1_req_i : m0_req_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    bus_sel   = sel_q;
    bus_req   = 1'b0;
    push      = 1'b0;
    lock_err  = 1'b0;
    case (state_q)
      OBI_ARB_IDLE: begin
        // Full blocks on registered count only, so a same-cycle rvalid cannot unblock.
        if (!fifo_full && (m0_req_i || m1_req_i)) begin
          bus_req = 1'b1;
          bus_sel = obi_arb_pick(m0_req_i, m1_req_i, rr_last_q, FIXED_PRIO != 0);
          if (obi_gnt_i) begin
            push      = 1'b1;
            rr_last_d = bus_sel;
          end else begin
            sel_d   = bus_sel;
            state_d = OBI_ARB_LOCKED;
          end
        end
      end
      OBI_ARB_LOCKED: begin
        if (sel_req) begin
          bus_req = 1'b1;
          if (obi_gnt_i) begin
            push      = 1'b1;
            rr_last_d = sel_q;
            state_d   = OBI_ARB_IDLE;
          end
        end else begin
          lock_err = 1'b1;
          state_d  = OBI_ARB_IDLE;
        end
      end
      default: state_d = OBI_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OBI_ARB_IDLE;
      sel_q     <= OBI_ID_M0;
      rr_last_q <= OBI_ID_M1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
    end
  end

  cv32e41s_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push && !rst),
    .push_id_i (bus_sel),
    .pop_i     (rsp_pop),
    .head_o    (head_id),
    .cnt_o     (cnt_q),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rsp_pop = obi_rvalid_i && !fifo_empty && !rst;

  assign obi_req_o   = bus_req && !rst;
  assign obi_addr_o  = !obi_req_o ? '0 : (bus_sel == OBI_ID_M1) ? m1_addr_i  : m0_addr_i;
  assign obi_we_o    = !obi_req_o ? '0 : (bus_sel == OBI_ID_M1) ? m1_we_i    : m0_we_i;
  assign obi_be_o    = !obi_req_o ? '0 : (bus_sel == OBI_ID_M1) ? m1_be_i    : m0_be_i;
  assign obi_wdata_o = !obi_req_o ? '0 : (bus_sel == OBI_ID_M1) ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o = obi_req_o && obi_gnt_i && (bus_sel == OBI_ID_M0);
  assign m1_gnt_o = obi_req_o && obi_gnt_i && (bus_sel == OBI_ID_M1);

  assign m0_rvalid_o = rsp_pop && (head_id == OBI_ID_M0);
  assign m1_rvalid_o = rsp_pop && (head_id == OBI_ID_M1);
  assign m0_rdata_o  = rst ? '0 : obi_rdata_i;
  assign m1_rdata_o  = rst ? '0 : obi_rdata_i;
  assign m0_err_o    = obi_err_i && !rst;
  assign m1_err_o    = obi_err_i && !rst;

  // A response with nothing outstanding means the bus answered a transaction we never issued.
  assign protocol_err_o = !rst && (lock_err || (obi_rvalid_i && (cnt_q == '0)));

endmodule
